// File: rtl/led_pkg.sv
// Shared types and helpers for the LED bank arbiter.
package led_pkg;

    localparam int NUM_REQ = 3;
    localparam int LED_W   = 8;

    typedef enum logic {IDLE, OWN} arb_state_t;

    // One-hot next requester after `from`, checked as from+1, from+2, from.
    function automatic logic [NUM_REQ-1:0] next_rr(
        input logic [NUM_REQ-1:0] req,
        input logic [1:0]         from
    );
        logic [NUM_REQ-1:0] g;
        int idx;
        g = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(from) + k) % NUM_REQ;
            if (g == '0 && req[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] g);
        logic [1:0] r;
        case (g)
            3'b010:  r = 2'd1;
            3'b100:  r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(TICK_DIV - 1)) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin time-slice owner of the 8-bit LED bank.
module led_bank_arbiter
    import led_pkg::*;
#(
    parameter int               TICK_DIV     = 50_000_000,
    parameter int               SLICE_TICKS  = 4,
    parameter logic [LED_W-1:0] IDLE_PATTERN = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [LED_W-1:0]   pat0,
    input  logic [LED_W-1:0]   pat1,
    input  logic [LED_W-1:0]   pat2,
    output logic [NUM_REQ-1:0] grant,
    output logic [LED_W-1:0]   LEDS,
    output logic               tick
);

    localparam int SW = $clog2(SLICE_TICKS + 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SW-1:0]      slice_q, slice_d;
    logic [1:0]         last_q, last_d;
    logic [LED_W-1:0]   leds_q, leds_d;
    logic [NUM_REQ-1:0] others;
    logic [1:0]         own;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign own    = onehot_idx(grant_q);
    assign others = req & ~grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        slice_d = slice_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    grant_d = next_rr(req, last_q);
                    state_d = OWN;
                    slice_d = '0;
                end
            end
            OWN: begin
                // A drop takes priority over a coincident slice expiry.
                if ((req & grant_q) == '0) begin
                    last_d  = own;
                    slice_d = '0;
                    if (others != '0) begin
                        grant_d = next_rr(others, own);
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else if (tick) begin
                    if (slice_q == SW'(SLICE_TICKS - 1)) begin
                        slice_d = '0;
                        if (others != '0) begin
                            grant_d = next_rr(others, own);
                            last_d  = own;
                        end
                    end else begin
                        slice_d = slice_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (grant_q)
            3'b001:  leds_d = pat0;
            3'b010:  leds_d = pat1;
            3'b100:  leds_d = pat2;
            default: leds_d = IDLE_PATTERN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            slice_q <= '0;
            last_q  <= 2'd2;
            leds_q  <= IDLE_PATTERN;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            slice_q <= slice_d;
            last_q  <= last_d;
            leds_q  <= leds_d;
        end
    end

    assign grant = grant_q;
    assign LEDS  = leds_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with TICK_DIV=4, SLICE_TICKS=2.
module tb_led_bank_arbiter;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic [7:0] pat0, pat1, pat2;
    logic [2:0] grant;
    logic [7:0] LEDS;
    logic       tick;

    int checks = 0;
    int errors = 0;

    led_bank_arbiter #(
        .TICK_DIV     (4),
        .SLICE_TICKS  (2),
        .IDLE_PATTERN (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .pat0  (pat0),
        .pat1  (pat1),
        .pat2  (pat2),
        .grant (grant),
        .LEDS  (LEDS),
        .tick  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reset for one edge; afterwards the prescaler count is 0, so the
    // tick is seen by the FSM on edges 4, 8, 12, ... counted from here.
    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [7:0] pat_of(input logic [2:0] g);
        case (g)
            3'b001:  return 8'h01;
            3'b010:  return 8'h0F;
            3'b100:  return 8'hAA;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        logic [2:0] eg, pg;
        reset = 1'b1;
        req   = 3'b000;
        pat0  = 8'h01;
        pat1  = 8'h0F;
        pat2  = 8'hAA;
        step();
        step();
        reset = 1'b0;

        // Idle after reset, tick every 4th cycle
        chk("rst_grant", {5'd0, grant}, 8'h00);
        chk("rst_leds", LEDS, 8'h00);
        chk("rst_tick", {7'd0, tick}, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("idle_tick", {7'd0, tick}, (i % 4 == 3) ? 8'h01 : 8'h00);
            chk("idle_grant", {5'd0, grant}, 8'h00);
        end

        // Full contention: 001 -> 010 -> 100 -> 001
        do_reset();
        req = 3'b111;
        pg  = 3'b000;
        for (int i = 1; i <= 25; i++) begin
            step();
            eg = (i < 8)  ? 3'b001 :
                 (i < 16) ? 3'b010 :
                 (i < 24) ? 3'b100 : 3'b001;
            chk("rr_grant", {5'd0, grant}, {5'd0, eg});
            chk("rr_leds", LEDS, pat_of(pg));
            pg = eg;
        end

        // Lone requester keeps the bank across slice expiries
        do_reset();
        req = 3'b010;
        for (int i = 1; i <= 40; i++) begin
            step();
            chk("solo_grant", {5'd0, grant}, 8'h02);
            chk("solo_leds", LEDS, (i >= 2) ? 8'h0F : 8'h00);
        end

        // Owner drop hands over to the pending requester, then idle
        do_reset();
        req = 3'b101;
        step();
        chk("drop_g0", {5'd0, grant}, 8'h01);
        step();
        chk("drop_l0", LEDS, 8'h01);
        req = 3'b100;
        step();
        chk("drop_g1", {5'd0, grant}, 8'h04);
        chk("drop_l1", LEDS, 8'h01);
        step();
        chk("drop_l2", LEDS, 8'hAA);
        req = 3'b000;
        step();
        chk("drop_g2", {5'd0, grant}, 8'h00);
        chk("drop_l3", LEDS, 8'hAA);
        step();
        chk("drop_l4", LEDS, 8'h00);

        // Drop coinciding with expiring tick at edge 8
        do_reset();
        req = 3'b011;
        for (int i = 1; i <= 7; i++) step();
        chk("coin_g0", {5'd0, grant}, 8'h01);
        req = 3'b010;
        step();
        chk("coin_g1", {5'd0, grant}, 8'h02);
        step();
        chk("coin_l1", LEDS, 8'h0F);
        req = 3'b111;
        for (int i = 10; i <= 15; i++) step();
        chk("coin_g2", {5'd0, grant}, 8'h02);
        step();
        chk("coin_g3", {5'd0, grant}, 8'h04);

        // Reset mid-slice with pending requests
        do_reset();
        req = 3'b001;
        for (int i = 1; i <= 5; i++) step();
        chk("mid_g0", {5'd0, grant}, 8'h01);
        reset = 1'b1;
        req   = 3'b110;
        step();
        chk("mid_rst_g", {5'd0, grant}, 8'h00);
        chk("mid_rst_l", LEDS, 8'h00);
        chk("mid_rst_t", {7'd0, tick}, 8'h00);
        reset = 1'b0;
        step();
        chk("mid_g1", {5'd0, grant}, 8'h02);
        chk("mid_l1", LEDS, 8'h00);
        step();
        chk("mid_l2", LEDS, 8'h0F);
        step();
        chk("mid_tick", {7'd0, tick}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
